// File: rtl/hamm_pkg.sv
// Shared constants for the Hamming codec error injector.
package hamm_pkg;

   typedef enum logic [1:0] {
      MODE_PASS  = 2'd0,
      MODE_FIXED = 2'd1,
      MODE_WALK  = 2'd2,
      MODE_RAND  = 2'd3
   } mode_e;

   localparam int unsigned         LFSR_W       = 16;
   // Taps x^16 + x^14 + x^13 + x^11 map to bits 15, 13, 12, 10.
   localparam logic [LFSR_W-1:0]   LFSR_TAPS    = 16'hB400;
   localparam logic [LFSR_W-1:0]   DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/hamm_lfsr16.sv
// 16-bit Fibonacci LFSR, shifting left, with synchronous load and advance enable.
module hamm_lfsr16
   import hamm_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
   input  logic              clk_i,
   input  logic              load_i,
   input  logic              en_i,
   output logic [LFSR_W-1:0] lfsr_o
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;

   // Next state: shift left, feedback is the XOR of the tapped bits.
   always_comb begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
   end

   // Load wins over advance so clear/reset always restore the seed.
   always_ff @(posedge clk_i) begin
      if (load_i) begin
         lfsr_q <= SEED;
      end else if (en_i) begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr_o = lfsr_q;

endmodule

// File: rtl/hamm_err_injector.sv
// Handshaked error injector between Hamming encoder and decoder.
// Corrupts every (cfg_period+1)-th accepted word with a PASS/FIXED/WALK/RAND mask.
module hamm_err_injector
   import hamm_pkg::*;
#(
   parameter int unsigned       W    = 7,
   parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   cfg_mode,
   input  logic [W-1:0] cfg_mask,
   input  logic         cfg_double,
   input  logic [7:0]   cfg_period,
   input  logic         cfg_clear,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [W-1:0] out_err_mask,
   output logic [15:0]  err_count
);

   localparam int unsigned WIDX_W = $clog2(W + 1);

   mode_e             mode;
   logic              accept;
   logic              inject;
   logic [W-1:0]      mask;
   logic [LFSR_W-1:0] lfsr;
   int unsigned       p1;
   int unsigned       p2;

   logic [7:0]        pcnt_q, pcnt_d;
   logic [WIDX_W-1:0] widx_q, widx_d;
   logic [15:0]       err_q, err_d;
   logic              out_valid_q, out_valid_d;
   logic [W-1:0]      out_data_q, out_data_d;
   logic [W-1:0]      out_mask_q, out_mask_d;

   assign mode     = mode_e'(cfg_mode);
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign inject   = (pcnt_q == cfg_period);

   hamm_lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk_i  (clk),
      .load_i (rst || cfg_clear),
      .en_i   (accept && (mode == MODE_RAND)),
      .lfsr_o (lfsr)
   );

   // Mask generation; bit position p (1 = MSB) lives at vector index W-p.
   always_comb begin
      mask = '0;
      p1   = (32'(lfsr[7:0]) % W) + 1;
      p2   = ((p1 + (32'(lfsr[15:8]) % (W - 1))) % W) + 1;
      if (inject) begin
         case (mode)
            MODE_FIXED: mask = cfg_mask;
            MODE_WALK: begin
               for (int unsigned i = 0; i < W; i++) begin
                  if ((W - i) == 32'(widx_q)) mask[i] = 1'b1;
               end
            end
            MODE_RAND: begin
               for (int unsigned i = 0; i < W; i++) begin
                  if (((W - i) == p1) || (cfg_double && ((W - i) == p2))) mask[i] = 1'b1;
               end
            end
            default: mask = '0;
         endcase
      end
   end

   // Counter, walk index and output-stage next state; clear overrides any same-cycle accept update.
   always_comb begin
      pcnt_d      = pcnt_q;
      widx_d      = widx_q;
      err_d       = err_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_mask_d  = out_mask_q;
      if (accept) begin
         pcnt_d      = inject ? '0 : pcnt_q + 8'd1;
         if (inject && (mode == MODE_WALK)) begin
            widx_d = (widx_q == WIDX_W'(W)) ? WIDX_W'(1) : widx_q + WIDX_W'(1);
         end
         if ((|mask) && (err_q != '1)) begin
            err_d = err_q + 16'd1;
         end
         out_valid_d = 1'b1;
         out_data_d  = in_data ^ mask;
         out_mask_d  = mask;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (cfg_clear) begin
         pcnt_d = '0;
         widx_d = WIDX_W'(1);
         err_d  = '0;
      end
   end

   // State registers with synchronous reset; reset drops any in-flight word.
   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt_q      <= '0;
         widx_q      <= WIDX_W'(1);
         err_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_mask_q  <= '0;
      end else begin
         pcnt_q      <= pcnt_d;
         widx_q      <= widx_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_mask_q  <= out_mask_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_err_mask = out_mask_q;
   assign err_count    = err_q;

endmodule
